codec_init_seq: RTL and testbench
=================================

CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEV_ADDR, 8'h34, I2C device address byte placed on wr_addr (write direction, R/W bit = 0).
- GAP_CYCLES, 16, idle sys_clk cycles inserted after each completed write.
- TIMEOUT, 65535, max sys_clk cycles from wr_req to wr_done before error.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- sys_clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, level; rising edge while IDLE/DONE/ERR starts the init sequence.
- host_req, in, 1, runtime register-write request; held until host_ack.
- host_reg, in, 8, register byte for the host write.
- host_data, in, 8, data byte for the host write.
- host_ack, out, 1, one-cycle pulse when the host write completes or errors.
- wr_addr, out, 8, device address to the writer.
- wr_reg, out, 8, register byte to the writer.
- wr_data, out, 8, data byte to the writer.
- wr_req, out, 1, one-cycle pulse requesting one 3-byte write.
- wr_done, in, 1, one-cycle pulse from the writer when the write finishes.
- busy, out, 1, high in every state except IDLE, DONE, ERR.
- init_done, out, 1, high in DONE.
- error, out, 1, high in ERR.
- err_index, out, 4, table index (or 4'hF for a host write) that timed out.

Function
REQ-003 The init table SHALL be a constant 9-entry ROM of {reg,data}: 0:1E/00, 1:0C/00, 2:0E/02, 3:10/00, 4:0A/00, 5:08/12, 6:00/17, 7:02/17, 8:12/01.
REQ-004 The FSM states SHALL be IDLE, ISSUE, WAIT, GAP, DONE, ERR, HISSUE, HWAIT, HGAP.
REQ-005 IDLE/DONE/ERR + start rising edge -> ISSUE; index cleared to 0, error/init_done cleared the same edge.
REQ-006 ISSUE SHALL drive wr_addr=DEV_ADDR, wr_reg/wr_data from ROM[index], pulse wr_req for exactly one cycle, then -> WAIT.
REQ-007 wr_addr/wr_reg/wr_data SHALL be registered and held stable from the wr_req cycle until wr_done.
REQ-008 WAIT: wr_done -> GAP; timeout counter reaching TIMEOUT without wr_done -> ERR with err_index=index.
REQ-009 GAP SHALL last exactly GAP_CYCLES cycles; then index==8 -> DONE, else index+1 and -> ISSUE.
REQ-010 A wr_done in any state other than WAIT/HWAIT SHALL be ignored.
REQ-011 Host writes SHALL be accepted only in DONE: host_req high in DONE -> HISSUE, latching host_reg/host_data.
REQ-012 HISSUE/HWAIT/HGAP SHALL mirror ISSUE/WAIT/GAP; host_ack pulses one cycle on entry to HGAP, then HGAP -> DONE.
REQ-013 HWAIT timeout SHALL -> ERR, err_index=4'hF, host_ack pulsed once.
REQ-014 The init sequence SHALL have priority: host_req during init SHALL be held off (no ack) until DONE.
REQ-015 start rising edge and host_req both seen in DONE on the same cycle: start wins; the host request stays pending.
REQ-016 start edges while busy SHALL be ignored.
REQ-017 Timeout counter SHALL be 16 bits, cleared on every wr_req, saturating at TIMEOUT.
REQ-018 Minimum spacing between wr_req pulses SHALL be wr_done latency + GAP_CYCLES + 2 cycles.

Reset
REQ-019 rst_n low SHALL immediately force IDLE, index=0, all counters 0, wr_req=0, host_ack=0, busy=0, init_done=0, error=0, err_index=0, wr_addr/wr_reg/wr_data=0.
REQ-020 Reset mid-write SHALL abandon the transfer; a late wr_done after release SHALL be ignored (REQ-010).
REQ-021 After rst_n release, the block SHALL stay IDLE until a start rising edge.

Verification
REQ-022 start edge, writer model acks 20 cycles after each wr_req -> 9 wr_req pulses, first {34,1E,00}, last {34,12,01}; init_done=1, busy=0.
REQ-023 Writer model never acks entry 3 -> error=1, err_index=3, busy=0, no further wr_req; next start edge restarts from entry 0.
REQ-024 host_req with reg 06/data 05, asserted at entry 2 -> no host write until DONE; then one wr_req {34,06,05}, one host_ack, back to DONE.
REQ-025 rst_n pulsed low during WAIT of entry 5 -> all outputs reset that cycle; wr_done 3 cycles later -> no state change.
REQ-026 In DONE, start edge and host_req on the same cycle -> init restarts at entry 0; host write serviced after the new DONE.

Source files
------------

// File: rtl/codec_init_seq.sv
// codec_init_seq: sequences a 9-entry codec register table through a 3-byte I2C writer, then serves host writes
//   sys_clk, rst_n (async active-low)          clock / reset
//   start                                      rising edge in IDLE/DONE/ERR (re)starts the init table
//   host_req, host_reg, host_data, host_ack    runtime write request held until the one-cycle ack
//   wr_addr, wr_reg, wr_data, wr_req, wr_done  writer handshake, fields held from wr_req to wr_done
//   busy, init_done, error, err_index          status; err_index is the timed-out entry or 4'hF for a host write
module codec_init_seq #(
  parameter logic [7:0] DEV_ADDR   = 8'h34,
  parameter int         GAP_CYCLES = 16,
  parameter int         TIMEOUT    = 65535
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       host_req,
  input  logic [7:0] host_reg,
  input  logic [7:0] host_data,
  output logic       host_ack,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  output logic       wr_req,
  input  logic       wr_done,
  output logic       busy,
  output logic       init_done,
  output logic       error,
  output logic [3:0] err_index
);
  typedef enum logic [3:0] {IDLE, ISSUE, WAIT, GAP, DONE, ERR, HISSUE, HWAIT, HGAP} state_t;
  state_t      state, nxt;
  logic        start_q;
  logic [3:0]  idx;
  logic [15:0] tcnt, gcnt, rom;
  logic        start_rise, tout, gend;
  assign start_rise = start & ~start_q;
  assign tout       = tcnt == 16'(TIMEOUT);
  assign gend       = gcnt == 16'(GAP_CYCLES - 1);
  assign busy       = !(state == IDLE || state == DONE || state == ERR);
  assign init_done  = state == DONE;
  assign error      = state == ERR;
  always_comb
    case (idx)
      4'd0:    rom = 16'h1E00;
      4'd1:    rom = 16'h0C00;
      4'd2:    rom = 16'h0E02;
      4'd3:    rom = 16'h1000;
      4'd4:    rom = 16'h0A00;
      4'd5:    rom = 16'h0812;
      4'd6:    rom = 16'h0017;
      4'd7:    rom = 16'h0217;
      4'd8:    rom = 16'h1201;
      default: rom = 16'h0000;
    endcase
  // start beats a simultaneous host_req in DONE; the host request simply stays pending
  always_comb begin
    nxt = state;
    case (state)
      IDLE, ERR: nxt = start_rise ? ISSUE : state;
      DONE:      nxt = start_rise ? ISSUE : host_req ? HISSUE : DONE;
      ISSUE:     nxt = WAIT;
      WAIT:      nxt = wr_done ? GAP : tout ? ERR : WAIT;
      GAP:       nxt = !gend ? GAP : idx == 4'd8 ? DONE : ISSUE;
      HISSUE:    nxt = HWAIT;
      HWAIT:     nxt = wr_done ? HGAP : tout ? ERR : HWAIT;
      HGAP:      nxt = gend ? DONE : HGAP;
      default:   nxt = IDLE;
    endcase
  end
  // wr_req is registered, so it rises the cycle after ISSUE/HISSUE together with the loaded fields
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      idx       <= 4'd0;
      tcnt      <= 16'd0;
      gcnt      <= 16'd0;
      wr_req    <= 1'b0;
      host_ack  <= 1'b0;
      err_index <= 4'd0;
      wr_addr   <= 8'd0;
      wr_reg    <= 8'd0;
      wr_data   <= 8'd0;
    end else begin
      state    <= nxt;
      start_q  <= start;
      wr_req   <= state == ISSUE || state == HISSUE;
      host_ack <= state == HWAIT && nxt != HWAIT;
      tcnt     <= (state == ISSUE || state == HISSUE) ? 16'd0 :
                  ((state == WAIT || state == HWAIT) && !tout) ? tcnt + 16'd1 : tcnt;
      gcnt     <= (state == GAP || state == HGAP) ? gcnt + 16'd1 : 16'd0;
      if (nxt == ISSUE) idx <= state == GAP ? idx + 4'd1 : 4'd0;
      if (state == ISSUE) {wr_addr, wr_reg, wr_data} <= {DEV_ADDR, rom};
      if (state == DONE && nxt == HISSUE) {wr_addr, wr_reg, wr_data} <= {DEV_ADDR, host_reg, host_data};
      if (nxt == ERR && state != ERR) err_index <= state == HWAIT ? 4'hF : idx;
    end
endmodule

// File: tb/tb_codec_init_seq.sv
// tb_codec_init_seq: randomized writer-latency bench for codec_init_seq against a table-level model
module tb_codec_init_seq;
  localparam int G = 16;
  localparam int TO = 300;
  localparam logic [15:0] TBL [9] = '{16'h1E00, 16'h0C00, 16'h0E02, 16'h1000, 16'h0A00,
                                      16'h0812, 16'h0017, 16'h0217, 16'h1201};
  logic sys_clk = 0, rst_n = 0, start = 0, host_req = 0, wr_done = 0;
  logic [7:0] host_reg = 0, host_data = 0;
  logic host_ack, wr_req, busy, init_done, error;
  logic [7:0] wr_addr, wr_reg, wr_data;
  logic [3:0] err_index;
  int checks = 0, errors = 0, cyc = 0, lat = 20, ack_at = -1, ack_cnt = 0;
  bit drop_en = 0;
  logic [15:0] drop_key = 0;
  logic [23:0] cap = 0;
  logic [23:0] wq[$];
  int wt[$];

  codec_init_seq #(.DEV_ADDR(8'h34), .GAP_CYCLES(G), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .host_req(host_req), .host_reg(host_reg),
    .host_data(host_data), .host_ack(host_ack), .wr_addr(wr_addr), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_req(wr_req), .wr_done(wr_done), .busy(busy), .init_done(init_done), .error(error),
    .err_index(err_index));

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model(input int i);
    return {8'h34, TBL[i]};
  endfunction

  // writer model: acks lat cycles after each wr_req unless the write matches the drop key
  always @(negedge sys_clk) begin
    if (wr_req) begin
      cap = {wr_addr, wr_reg, wr_data};
      wq.push_back(cap);
      wt.push_back(cyc);
      if (!(drop_en && {wr_reg, wr_data} == drop_key)) ack_at = cyc + lat;
    end
    wr_done = cyc == ack_at;
    if (wr_done && busy) chk("hold", {wr_addr, wr_reg, wr_data}, cap);
    if (host_ack) ack_cnt++;
  end

  task automatic clr();
    wq.delete();
    wt.delete();
  endtask

  task automatic pulse_start();
    @(negedge sys_clk) start = 1;
    @(negedge sys_clk);
    @(negedge sys_clk) start = 0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge sys_clk);
      n++;
    end
    chk("idle_bound", busy, 0);
  endtask

  task automatic wait_req(input int k);
    int n = 0;
    while (wq.size() < k && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("req_bound", wq.size() >= k, 1);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!host_ack && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("ack_bound", host_ack, 1);
    host_req = 0;
  endtask

  task automatic check_init(input int l);
    chk("init_count", wq.size(), 9);
    for (int i = 0; i < 9 && i < wq.size(); i++) chk("entry", wq[i], model(i));
    for (int i = 1; i < 9 && i < wt.size(); i++) chk("spacing", wt[i] - wt[i-1], l + G + 2);
  endtask

  task automatic check_reset();
    chk("reset_outs", {wr_req, host_ack, busy, init_done, error, err_index, wr_addr, wr_reg, wr_data}, 0);
  endtask

  initial begin
    int rc, a0;
    logic [7:0] r, d;
    repeat (3) @(negedge sys_clk);
    check_reset();
    rst_n = 1;
    repeat (10) @(negedge sys_clk);
    chk("idle_hold", {busy, init_done, 4'(wq.size())}, 0);

    for (int k = 0; k < 2; k++) begin
      lat = $urandom_range(3, 30);
      clr();
      pulse_start();
      chk("busy_run", busy, 1);
      wait_idle(5000);
      check_init(lat);
      chk("done_flags", {init_done, error, busy}, 3'b100);
    end

    lat = $urandom_range(3, 30);
    drop_en = 1;
    drop_key = TBL[3];
    clr();
    pulse_start();
    wait_idle(5000);
    chk("err_flags", {error, init_done, busy}, 3'b100);
    chk("err_index", err_index, 3);
    repeat (100) @(negedge sys_clk);
    chk("no_more_req", wq.size(), 4);
    drop_en = 0;
    clr();
    pulse_start();
    chk("restart_clear", {error, init_done}, 0);
    wait_idle(5000);
    check_init(lat);

    clr();
    a0 = ack_cnt;
    pulse_start();
    wait_req(3);
    host_reg = 8'h06;
    host_data = 8'h05;
    host_req = 1;
    wait_ack();
    chk("host_after_init", wq.size(), 10);
    chk("host_write", wq[wq.size()-1], 24'h340605);
    repeat (G + 2) @(negedge sys_clk);
    chk("host_ack_once", ack_cnt - a0, 1);
    chk("host_back_done", {init_done, busy}, 2'b10);

    for (int k = 0; k < 3; k++) begin
      lat = $urandom_range(3, 30);
      r = 8'($urandom);
      d = 8'($urandom);
      clr();
      a0 = ack_cnt;
      host_reg = r;
      host_data = d;
      @(negedge sys_clk) host_req = 1;
      wait_ack();
      chk("rand_host", wq.size() > 0 ? wq[0] : 24'hx, {8'h34, r, d});
      repeat (G + 2) @(negedge sys_clk);
      chk("rand_ack_once", ack_cnt - a0, 1);
      chk("rand_done", init_done, 1);
    end

    drop_en = 1;
    drop_key = {8'h5A, 8'hA5};
    host_reg = 8'h5A;
    host_data = 8'hA5;
    a0 = ack_cnt;
    @(negedge sys_clk) host_req = 1;
    wait_ack();
    repeat (5) @(negedge sys_clk);
    chk("host_to_err", {error, init_done, busy}, 3'b100);
    chk("host_err_index", err_index, 4'hF);
    chk("host_to_ack", ack_cnt - a0, 1);
    drop_en = 0;

    lat = 20;
    clr();
    pulse_start();
    wait_req(6);
    rc = wt[5];
    while (cyc < rc + 17) @(negedge sys_clk);
    rst_n = 0;
    #1 check_reset();
    @(negedge sys_clk) rst_n = 1;
    repeat (30) @(negedge sys_clk);
    chk("late_done_ignored", {busy, init_done, error}, 0);
    chk("late_no_req", wq.size(), 6);

    lat = $urandom_range(3, 30);
    pulse_start();
    wait_idle(5000);
    r = 8'($urandom);
    d = 8'($urandom);
    clr();
    host_reg = r;
    host_data = d;
    @(negedge sys_clk) begin
      start = 1;
      host_req = 1;
    end
    @(negedge sys_clk);
    @(negedge sys_clk) start = 0;
    wait_ack();
    chk("race_count", wq.size(), 10);
    chk("race_first", wq.size() > 0 ? wq[0] : 24'hx, model(0));
    chk("race_host", wq.size() > 0 ? wq[wq.size()-1] : 24'hx, {8'h34, r, d});
    repeat (G + 2) @(negedge sys_clk);
    chk("race_done", init_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
